alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Decode/issue pipeline stage on the producer side of the ALU operand interface.
//  Decodes one RV32I instruction per handshake into ALU_Control, operand_A and operand_B.
//  Registers those fields, with writeback sideband, for the execute stage that drives the ALU.
//  Single-entry valid/ready pipeline register with flush; sits between fetch and execute.
// PARAMETERS
//  XLEN      32        datapath width; only 32 is supported
//  ILLEGAL_OP 6'h3F    ALU_Control code issued for undecodable instructions
// PORTS
//  clock        in   1     sole clock, rising edge
//  reset_n      in   1     asynchronous assert, active-low reset
//  in_valid     in   1     fetch presents instr/pc
//  in_ready     out  1     stage accepts this cycle
//  instr        in   32    instruction word
//  pc           in   32    instruction address
//  rs1_addr     out  5     combinational instr[19:15], to register file
//  rs2_addr     out  5     combinational instr[24:20], to register file
//  rs1_data     in   32    register file read data, same cycle
//  rs2_data     in   32    register file read data, same cycle
//  flush        in   1     kill held and incoming instruction
//  out_valid    out  1     issued bundle valid
//  out_ready    in   1     execute stage accepts
//  ALU_Control  out  6     operation code, encodings below
//  operand_A    out  32    ALU operand A
//  operand_B    out  32    ALU operand B
//  rd           out  5     destination register
//  reg_write    out  1     writeback enable; forced 0 when rd==0
//  mem_write    out  1     STORE instruction
//  store_data   out  32    rs2_data captured for stores
//  illegal      out  1     undecodable instruction flag
// BEHAVIOUR
//  Reset: out_valid=0, all registered outputs=0, ALU_Control=ADD (0).
//  Encoding: ADD=0 SUB=1 OR=2 XOR=3 AND=4 SLL=5 SRL=6 SRA=7 JAL=8 JALR=9 SLT=10 SLTU=11 STORE=12.
//  Handshake: in_ready = !out_valid | out_ready (combinational). Transfer = in_valid & in_ready.
//  Latency: decoded bundle appears exactly 1 cycle after transfer. Bundle holds stable while out_valid & !out_ready.
//  Flush: has priority. Next cycle out_valid=0 and no capture, even if in_valid & in_ready.
//  out_valid drops when out_ready & !transfer.
//  Decode, registered at transfer:
//   OP 0110011: A=rs1, B=rs2; funct7[5] selects SUB/SRA; funct3 maps to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
//   OP-IMM 0010011: B=sext(imm_i). Shift ops: B={27'b0,instr[24:20]}. funct7 other than 0/0x20 (SRAI) is illegal.
//   LOAD 0000011: ADD, B=sext(imm_i), reg_write=1.
//   STORE 0100011: STORE, B=sext(imm_s), mem_write=1, reg_write=0.
//   LUI 0110111: ADD, A=0, B={imm_u,12'b0}.  AUIPC 0010111: ADD, A=pc, B={imm_u,12'b0}.
//   JAL 1101111: JAL, A=pc+4.  JALR 1100111 with funct3=0: JALR, A=pc+4. Targets are not computed here.
//   BRANCH 1100011: SUB, A=rs1, B=rs2, reg_write=0.
//   Any other opcode: ALU_Control=ILLEGAL_OP, illegal=1, reg_write=0, mem_write=0.
//  Arithmetic: pc+4 wraps mod 2^32. Shift B is always <=31, so the ALU never sees over-range shifts.
//  Simultaneous drain and refill (out_ready & in_valid, out_valid=1): new bundle loads; no bubble.
//  Reset asserted mid-handshake: bundle is discarded; out_valid=0 immediately (asynchronous).
// STRUCTURE
//  Shared package/include alu_defs: ALU_Control encodings, opcode constants, ILLEGAL_OP.
//  The ALU includes the same alu_defs.
//  One sub-module, alu_issue_decode: purely combinational instr/pc/rs data -> bundle.
//  The top level holds only the pipeline register and handshake logic.
// TESTING
//  1. add x3,x1,x2 with rs1=5, rs2=7 -> next cycle out_valid=1, ALU_Control=0, A=5, B=7, rd=3, reg_write=1.
//  2. srai x4,x1,3 (0x4030D213) -> ALU_Control=7, B=3; funct7=0x10 variant -> illegal=1, ALU_Control=0x3F.
//  3. sw x2,-4(x1) with rs1=0x100, rs2=0xAB -> ALU_Control=12, A=0x100, B=0xFFFFFFFC, mem_write=1, store_data=0xAB.
//  4. jal at pc=0xFFFFFFFC -> ALU_Control=8, A=0x0 (wrap); addi x0,x0,1 -> reg_write=0.
//  5. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and bundle stable; out_ready=1 -> back-to-back issue, no bubble.
//  6. flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle; reset_n low mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/alu_defs.sv
// Shared ALU definitions: ALU_Control encodings, RV32I opcodes, issue bundle layout.
// The issue stage and the ALU both import this package so the codes stay in sync.
package alu_defs;

  localparam int XLEN_DEFAULT = 32;

  // ALU_Control encodings
  localparam logic [5:0] ALU_ADD   = 6'd0;
  localparam logic [5:0] ALU_SUB   = 6'd1;
  localparam logic [5:0] ALU_OR    = 6'd2;
  localparam logic [5:0] ALU_XOR   = 6'd3;
  localparam logic [5:0] ALU_AND   = 6'd4;
  localparam logic [5:0] ALU_SLL   = 6'd5;
  localparam logic [5:0] ALU_SRL   = 6'd6;
  localparam logic [5:0] ALU_SRA   = 6'd7;
  localparam logic [5:0] ALU_JAL   = 6'd8;
  localparam logic [5:0] ALU_JALR  = 6'd9;
  localparam logic [5:0] ALU_SLT   = 6'd10;
  localparam logic [5:0] ALU_SLTU  = 6'd11;
  localparam logic [5:0] ALU_STORE = 6'd12;

  // Code issued for anything the decoder does not recognise
  localparam logic [5:0] ILLEGAL_OP_DEFAULT = 6'h3F;

  // funct7 value selecting SUB / SRA / SRAI
  localparam logic [6:0] F7_ALT = 7'h20;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  // Everything the execute stage needs for one instruction
  typedef struct packed {
    logic [5:0]  alu_ctrl;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic [31:0] store_data;
    logic        illegal;
  } issue_bundle_t;

  // Shared funct3 map for OP and OP-IMM; alt picks SUB over ADD and SRA over SRL
  function automatic logic [5:0] funct3_to_op(input logic [2:0] funct3, input logic alt);
    logic [5:0] op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decoder: instruction, pc and register read data in,
// one issue bundle out. Holds no state; the pipeline register lives in the top.
module alu_issue_decode
  import alu_defs::*;
#(
  parameter logic [5:0] ILLEGAL_OP = ILLEGAL_OP_DEFAULT
) (
  input  logic [31:0]   instr,
  input  logic [31:0]   pc,
  input  logic [31:0]   rs1_data,
  input  logic [31:0]   rs2_data,
  output issue_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic [31:0] pc_plus4;
  logic        is_shift_imm;
  logic        write_back;
  logic        bad;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign rd_field     = instr[11:7];
  assign imm_i        = {{20{instr[31]}}, instr[31:20]};
  assign imm_s        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u        = {instr[31:12], 12'b0};
  // Shift amounts come straight from the 5-bit field, so B never exceeds 31
  assign shamt        = {27'b0, instr[24:20]};
  // Wraps naturally modulo 2^32
  assign pc_plus4     = pc + 32'd4;
  assign is_shift_imm = (funct3 == 3'd1) || (funct3 == 3'd5);

  // Decode the instruction into the issue bundle; illegal forms override at the end
  always_comb begin
    bundle          = '0;
    bundle.alu_ctrl = ALU_ADD;
    bundle.rd       = rd_field;
    write_back      = 1'b0;
    bad             = 1'b0;
    case (opcode)
      OPC_OP: begin
        bundle.alu_ctrl  = funct3_to_op(funct3, funct7[5]);
        bundle.operand_a = rs1_data;
        bundle.operand_b = rs2_data;
        write_back       = 1'b1;
      end
      OPC_OP_IMM: begin
        bundle.alu_ctrl  = funct3_to_op(funct3, (funct3 == 3'd5) && (funct7 == F7_ALT));
        bundle.operand_a = rs1_data;
        write_back       = 1'b1;
        if (is_shift_imm) begin
          bundle.operand_b = shamt;
          // SLLI/SRLI need funct7=0; only the right shift may use the SRAI pattern
          bad = !((funct7 == 7'h00) || ((funct3 == 3'd5) && (funct7 == F7_ALT)));
        end else begin
          bundle.operand_b = imm_i;
        end
      end
      OPC_LOAD: begin
        bundle.operand_a = rs1_data;
        bundle.operand_b = imm_i;
        write_back       = 1'b1;
      end
      OPC_STORE: begin
        bundle.alu_ctrl   = ALU_STORE;
        bundle.operand_a  = rs1_data;
        bundle.operand_b  = imm_s;
        bundle.mem_write  = 1'b1;
        bundle.store_data = rs2_data;
      end
      OPC_LUI: begin
        bundle.operand_b = imm_u;
        write_back       = 1'b1;
      end
      OPC_AUIPC: begin
        bundle.operand_a = pc;
        bundle.operand_b = imm_u;
        write_back       = 1'b1;
      end
      OPC_JAL: begin
        bundle.alu_ctrl  = ALU_JAL;
        bundle.operand_a = pc_plus4;
        write_back       = 1'b1;
      end
      OPC_JALR: begin
        bundle.alu_ctrl  = ALU_JALR;
        bundle.operand_a = pc_plus4;
        write_back       = 1'b1;
        bad              = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        bundle.alu_ctrl  = ALU_SUB;
        bundle.operand_a = rs1_data;
        bundle.operand_b = rs2_data;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      bundle.alu_ctrl  = ILLEGAL_OP;
      bundle.illegal   = 1'b1;
      bundle.operand_a = '0;
      bundle.operand_b = '0;
      write_back       = 1'b0;
    end
    // x0 is never written
    bundle.reg_write = write_back && (rd_field != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: single-entry valid/ready pipeline register in front of execute.
// Decoding happens in alu_issue_decode; this level only captures and hands off.
module alu_issue_stage
  import alu_defs::*;
#(
  parameter int         XLEN       = XLEN_DEFAULT,
  parameter logic [5:0] ILLEGAL_OP = ILLEGAL_OP_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      ALU_Control,
  output logic [XLEN-1:0] operand_A,
  output logic [XLEN-1:0] operand_B,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_write,
  output logic [XLEN-1:0] store_data,
  output logic            illegal
);

  issue_bundle_t dec_bundle;
  issue_bundle_t bundle_reg;
  logic          out_valid_reg;
  logic          transfer;

  // Register file addresses are read in the same cycle the instruction is presented
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  // Accept when empty or when the held bundle leaves this cycle
  assign in_ready = !out_valid_reg || out_ready;
  assign transfer = in_valid && in_ready;

  alu_issue_decode #(
    .ILLEGAL_OP(ILLEGAL_OP)
  ) u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .bundle   (dec_bundle)
  );

  // Valid flag: flush wins, then capture, then drain
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (transfer) begin
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Bundle payload: load only on an unflushed transfer, otherwise hold stable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bundle_reg <= '0;
    end else if (transfer && !flush) begin
      bundle_reg <= dec_bundle;
    end
  end

  assign out_valid   = out_valid_reg;
  assign ALU_Control = bundle_reg.alu_ctrl;
  assign operand_A   = bundle_reg.operand_a;
  assign operand_B   = bundle_reg.operand_b;
  assign rd          = bundle_reg.rd;
  assign reg_write   = bundle_reg.reg_write;
  assign mem_write   = bundle_reg.mem_write;
  assign store_data  = bundle_reg.store_data;
  assign illegal     = bundle_reg.illegal;

endmodule
